// File: rtl/mem_port_arbiter.sv
// Two-way arbiter sharing one synchronous 4K x 16 memory port between the CPU
// datapath and the host program loader. One access is granted per clock and the
// loser is stalled. Fairness comes from a registered last-grant pointer plus a
// bounded loader burst lock. Read data comes back one cycle after the grant.

// Per-side read return: flags a granted read and presents the memory output
// in the following cycle, then keeps that word until the next read returns.
module mem_port_rd_ret #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd_issue,
  input  logic [DW-1:0] mem_outdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q,  rdata_d;

  // The memory output already holds the word in the return cycle, so it is
  // shown directly and also captured for the cycles after.
  always_comb begin
    rvalid_d = rd_issue;
    rdata_d  = rvalid_q ? mem_outdata : rdata_q;
  end

  // Return state; an async reset discards any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_d;

endmodule

module mem_port_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int HOLD_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  // CPU side
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  // loader side
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_rvalid,
  // memory side
  output logic [AW-1:0] mem_adress,
  output logic          mem_write,
  output logic [DW-1:0] mem_indata,
  input  logic [DW-1:0] mem_outdata
);

  localparam int NUM_SIDES = 2;
  localparam int SIDE_CPU  = 0;
  localparam int SIDE_LDR  = 1;
  localparam int CNT_W     = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);

  typedef enum logic { GNT_CPU = 1'b0, GNT_LDR = 1'b1 } grant_e;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_req_t;

  port_req_t cpu_r, ldr_r;

  grant_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;

  logic cpu_gnt, ldr_win, hold_ldr;

  logic [NUM_SIDES-1:0]         rd_issue;
  logic [NUM_SIDES-1:0]         rvalid_arr;
  logic [NUM_SIDES-1:0][DW-1:0] rdata_arr;

  assign cpu_r = '{req: cpu_req, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ldr_r = '{req: ldr_req, we: ldr_we, addr: ldr_addr, wdata: ldr_wdata};

  // Grant decision: a lone requester wins; on a tie the loader may keep the
  // port for a bounded locked burst, otherwise the side not served last wins.
  always_comb begin
    hold_ldr = (last_grant_q == GNT_LDR) && ldr_lock && (burst_cnt_q < HOLD_CNT);
    ldr_win  = ldr_r.req && (!cpu_r.req || hold_ldr || (last_grant_q == GNT_CPU));
    cpu_gnt  = cpu_r.req && !ldr_win;
  end

  assign ldr_gnt   = ldr_win;
  assign cpu_stall = cpu_r.req && !cpu_gnt;

  // Memory port mux; the CPU address is parked on the bus when idle. Writes
  // are suppressed while reset is held so nothing lands during reset.
  always_comb begin
    mem_adress = ldr_gnt ? ldr_r.addr  : cpu_r.addr;
    mem_indata = ldr_gnt ? ldr_r.wdata : cpu_r.wdata;
    mem_write  = reset_n && ((cpu_gnt && cpu_r.we) || (ldr_gnt && ldr_r.we));
  end

  // Next pointer and burst length: the burst only grows while the CPU is
  // actually waiting on a locked loader, and any break in that restarts it.
  always_comb begin
    last_grant_d = last_grant_q;
    if (cpu_gnt)      last_grant_d = GNT_CPU;
    else if (ldr_gnt) last_grant_d = GNT_LDR;

    burst_cnt_d = burst_cnt_q;
    if (cpu_gnt || !ldr_lock || !cpu_r.req)
      burst_cnt_d = '0;
    else if (ldr_gnt && (burst_cnt_q < HOLD_CNT))
      burst_cnt_d = burst_cnt_q + 1'b1;
  end

  // Arbitration state; reset points at the loader so the first tie goes to the CPU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GNT_LDR;
      burst_cnt_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign rd_issue[SIDE_CPU] = cpu_gnt && !cpu_r.we;
  assign rd_issue[SIDE_LDR] = ldr_gnt && !ldr_r.we;

  mem_port_rd_ret #(.DW(DW)) u_rd_ret [NUM_SIDES-1:0] (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_issue    (rd_issue),
    .mem_outdata (mem_outdata),
    .rvalid      (rvalid_arr),
    .rdata       (rdata_arr)
  );

  assign cpu_rvalid = rvalid_arr[SIDE_CPU];
  assign cpu_rdata  = rdata_arr[SIDE_CPU];
  assign ldr_rvalid = rvalid_arr[SIDE_LDR];
  assign ldr_rdata  = rdata_arr[SIDE_LDR];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a reference model of the arbitration rules and memory contents.
module tb_mem_port_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int HOLD = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_gnt, ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic [AW-1:0] mem_adress;
  logic          mem_write;
  logic [DW-1:0] mem_indata;
  logic [DW-1:0] mem_outdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_adress(mem_adress), .mem_write(mem_write), .mem_indata(mem_indata),
    .mem_outdata(mem_outdata)
  );

  // Synchronous memory device behind the port.
  logic [DW-1:0] dev [DEPTH];
  logic          clr_mem = 1'b1;
  always @(posedge clk) begin
    if (clr_mem) for (int i = 0; i < DEPTH; i++) dev[i] <= '0;
    else if (mem_write) dev[mem_adress] <= mem_indata;
    mem_outdata <= dev[mem_adress];
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who was served last (0 CPU, 1 LDR), how many loader
  // grants in a row the waiting CPU has seen under lock, expected memory image
  // and what each side should see on its read return.
  int            m_last, m_streak, m_g;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            e_cv, e_lv;
  logic [DW-1:0] e_cd, e_ld;
  bit            obs_stall, obs_ldr, obs_cv, obs_lv;
  logic [DW-1:0] obs_cd, obs_ld;

  task automatic m_rst();
    m_last = 1; m_streak = 0;
    e_cv = 0; e_lv = 0; e_cd = '0; e_ld = '0;
  endtask

  // -1 none, 0 CPU, 1 LDR
  function automatic int pick();
    if (!cpu_req && !ldr_req) return -1;
    if (cpu_req && !ldr_req)  return 0;
    if (!cpu_req && ldr_req)  return 1;
    if (m_last == 1 && ldr_lock && m_streak < HOLD) return 1;
    return 1 - m_last;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit wr;
    @(negedge clk);
    m_g = pick();
    wr  = (m_g == 0 && cpu_we) || (m_g == 1 && ldr_we);
    chk("cpu_stall",  32'(cpu_stall), 32'(cpu_req && m_g != 0));
    chk("ldr_gnt",    32'(ldr_gnt),   32'(m_g == 1));
    chk("mem_write",  32'(mem_write), 32'(wr));
    chk("mem_adress", 32'(mem_adress), 32'(m_g == 1 ? ldr_addr : cpu_addr));
    if (wr) chk("mem_indata", 32'(mem_indata), 32'(m_g == 1 ? ldr_wdata : cpu_wdata));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv));
    chk("ldr_rvalid", 32'(ldr_rvalid), 32'(e_lv));
    chk("cpu_rdata",  32'(cpu_rdata),  32'(e_cd));
    chk("ldr_rdata",  32'(ldr_rdata),  32'(e_ld));
    obs_stall = cpu_stall; obs_ldr = ldr_gnt;
    obs_cv = cpu_rvalid; obs_lv = ldr_rvalid; obs_cd = cpu_rdata; obs_ld = ldr_rdata;
    @(posedge clk);
    e_cv = (m_g == 0 && !cpu_we);
    if (e_cv) e_cd = ref_mem[cpu_addr];
    e_lv = (m_g == 1 && !ldr_we);
    if (e_lv) e_ld = ref_mem[ldr_addr];
    if (m_g == 0 && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    if (m_g == 1 && ldr_we) ref_mem[ldr_addr] = ldr_wdata;
    if (m_g == 0 || !ldr_lock || !cpu_req) m_streak = 0;
    else if (m_streak < HOLD) m_streak++;
    if (m_g >= 0) m_last = m_g;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_rst();
    #1;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("rst_mem_write",  32'(mem_write),  32'd0);
    chk("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
    chk("rst_ldr_rdata",  32'(ldr_rdata),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; ldr_req = 0; ldr_we = 0; ldr_lock = 0;
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 4) == 0) return {AW{1'b1}};
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cpu_hold, ldr_hold;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    // reset with both sides requesting; first tie afterwards goes to the CPU
    cpu_req = 1; cpu_addr = 12'h001; ldr_req = 1; ldr_addr = 12'h002;
    do_reset();
    clr_mem = 1'b0;
    cyc();
    chk("t1_first_tie_ldr", 32'(obs_ldr), 32'd0);
    chk("t1_cpu_no_stall",  32'(obs_stall), 32'd0);
    // CPU alone: write then read back
    idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h005; cpu_wdata = 16'h1234;
    cyc(); chk("t2_wr_stall", 32'(obs_stall), 32'd0);
    cpu_we = 0;
    cyc(); chk("t2_rd_stall", 32'(obs_stall), 32'd0);
    cpu_req = 0;
    cyc();
    chk("t2_rvalid", 32'(obs_cv), 32'd1);
    chk("t2_rdata",  32'(obs_cd), 32'h1234);
    // unlocked tie alternates
    idle(); do_reset();
    cpu_req = 1; ldr_req = 1; cpu_addr = 12'h005; ldr_addr = 12'h003;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_alt_ldr_gnt", 32'(obs_ldr),   32'(i % 2));
      chk("t3_alt_stall",   32'(obs_stall), 32'(i % 2));
    end
    // locked loader burst is capped at HOLD grants
    idle(); cpu_req = 1;
    cyc();
    ldr_req = 1; ldr_lock = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t4_burst_ldr_gnt", 32'(obs_ldr), 32'(i != HOLD));
    end
    // top address: CPU writes first, loader then reads the new word
    idle(); do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'hFFF; cpu_wdata = 16'hBEEF;
    ldr_req = 1; ldr_we = 0; ldr_addr = 12'hFFF;
    cyc(); chk("t5_cpu_first", 32'(obs_ldr), 32'd0);
    cpu_req = 0;
    cyc(); chk("t5_ldr_next", 32'(obs_ldr), 32'd1);
    ldr_req = 0;
    cyc();
    chk("t5_ldr_rvalid", 32'(obs_lv), 32'd1);
    chk("t5_ldr_rdata",  32'(obs_ld), 32'hBEEF);
    // reset in the middle of a granted read drops it
    idle(); cpu_req = 1; cpu_addr = 12'h005;
    @(negedge clk);
    chk("t6_granted", 32'(cpu_stall), 32'd0);
    reset_n = 1'b0; m_rst();
    #1;
    chk("t6_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("t6_rst_mem_write", 32'(mem_write), 32'd0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
    ldr_req = 1;
    cyc();
    chk("t6_no_rvalid", 32'(obs_cv), 32'd0);
    chk("t6_cpu_first", 32'(obs_ldr), 32'd0);
    // randomized traffic; a stalled side keeps its request unchanged
    idle(); cyc();
    cpu_hold = 0; ldr_hold = 0;
    for (int n = 0; n < 800; n++) begin
      if (!cpu_hold) begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = raddr(); cpu_wdata = DW'($urandom);
      end
      if (!ldr_hold) begin
        ldr_req = ($urandom_range(0, 3) != 0); ldr_we = $urandom_range(0, 1) == 1;
        ldr_addr = raddr(); ldr_wdata = DW'($urandom);
      end
      ldr_lock = ($urandom_range(0, 3) != 0);
      cyc();
      cpu_hold = cpu_req && m_g != 0;
      ldr_hold = ldr_req && m_g != 1;
    end
    idle(); cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
